// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: loads two operands into Datapath data memory, releases the Datapath,
// then waits for a PC self-loop (halt) or a cycle budget (timeout). Abort input: RUN_CTRL_ABORT_EN.
module cpu_run_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int CYC_W       = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_STABLE = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       res_in,
`ifdef RUN_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              cpu_rst,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       result,
  output logic [CYC_W-1:0]  cycles
);

  localparam int              ST_W    = $clog2(HALT_STABLE);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(HALT_STABLE - 1);
  localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(MAX_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RELEASE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       opb_q, opb_d;
  logic [31:0]       pc_prev, pc_prev_d;
  logic [ST_W-1:0]   stable_q, stable_d, stable_inc;
  logic [CYC_W-1:0]  cycles_inc, cycles_d;
  logic              accept, in_run, pc_match, halt, expired, abort_hit;
  logic              cpu_rst_d, dm_we_d, busy_d, done_d, timeout_d;
  logic [ADDR_W-1:0] dm_addr_d;
  logic [31:0]       dm_wdata_d, result_d;

  assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign in_run     = (state_q == S_RUN);
  assign pc_match   = (pc_in == pc_prev);
  assign stable_inc = (stable_q == ST_MAX) ? stable_q : stable_q + ST_W'(1);
  assign halt       = in_run && pc_match && (stable_inc == ST_MAX);
  assign cycles_inc = cycles + CYC_W'(1);
  assign expired    = in_run && (cycles_inc == CYC_MAX);

`ifdef RUN_CTRL_ABORT_EN
  logic aborted_d;
  assign abort_hit = abort && (state_q inside {S_LOAD_A, S_LOAD_B, S_RELEASE, S_RUN});
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD_A;
      S_LOAD_A:       state_d = S_LOAD_B;
      S_LOAD_B:       state_d = S_RELEASE;
      S_RELEASE:      state_d = S_RUN;
      S_RUN:          if (halt || expired) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_DONE;
  end

  // Outputs are registered, so their next values are decoded from the next state.
  always_comb begin
    cpu_rst_d  = (state_d != S_RUN);
    dm_we_d    = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    busy_d     = state_d inside {S_LOAD_A, S_LOAD_B, S_RELEASE, S_RUN};
    done_d     = (state_d == S_DONE);
    dm_addr_d  = dm_addr;
    dm_wdata_d = dm_wdata;
    opb_d      = opb_q;
    timeout_d  = timeout;
    result_d   = result;
    cycles_d   = cycles;
    stable_d   = stable_q;
    pc_prev_d  = pc_prev;

    if (state_d == S_LOAD_A) begin
      dm_addr_d  = ADDR_W'(OPA_ADDR);
      dm_wdata_d = op_a;
    end else if (state_d == S_LOAD_B) begin
      dm_addr_d  = ADDR_W'(OPB_ADDR);
      dm_wdata_d = opb_q;
    end

    if (accept) begin
      opb_d     = op_b;
      timeout_d = 1'b0;
      cycles_d  = '0;
    end

    if (state_q == S_RELEASE) begin
      cycles_d = '0;
      stable_d = '0;
    end

    if (in_run) begin
      cycles_d  = cycles_inc;
      pc_prev_d = pc_in;
      stable_d  = pc_match ? stable_inc : '0;
      // Halt beats a coincident timeout; abort beats both and keeps the old result.
      if ((halt || expired) && !abort_hit) begin
        result_d  = res_in;
        timeout_d = expired && !halt;
      end
    end

    if (abort_hit) timeout_d = 1'b0;
  end

`ifdef RUN_CTRL_ABORT_EN
  always_comb begin
    aborted_d = aborted;
    if (accept)    aborted_d = 1'b0;
    if (abort_hit) aborted_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst  <= 1'b1;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      result   <= '0;
      cycles   <= '0;
      opb_q    <= '0;
      pc_prev  <= '0;
      stable_q <= '0;
`ifdef RUN_CTRL_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      cpu_rst  <= cpu_rst_d;
      dm_we    <= dm_we_d;
      dm_addr  <= dm_addr_d;
      dm_wdata <= dm_wdata_d;
      busy     <= busy_d;
      done     <= done_d;
      timeout  <= timeout_d;
      result   <= result_d;
      cycles   <= cycles_d;
      opb_q    <= opb_d;
      pc_prev  <= pc_prev_d;
      stable_q <= stable_d;
`ifdef RUN_CTRL_ABORT_EN
      aborted  <= aborted_d;
`endif
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-side run controller that sequences one program execution on the Datapath.
- Per run: writes two operands into data memory, holds the Datapath in reset for one extra cycle, then releases it.
- Detects program halt, defined as the PC self-looping, or a cycle-budget timeout.
- Latches the result register value and reports done with the cycle count.
- Replaces hand-timed bench sequencing (fixed delays, then peeking at register 30) with a handshake.

Parameters:
- ADDR_W, 10: data-memory word-address width.
- CYC_W, 16: run-cycle counter width.
- MAX_CYCLES, 1000: RUN-cycle budget before timeout; must be at most 2^CYC_W-1.
- HALT_STABLE, 4: consecutive cycles with an unchanged PC that count as a halt; minimum 2.
- OPA_ADDR, 0: data-memory word address for operand A.
- OPB_ADDR, 1: data-memory word address for operand B.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- op_a  in  32  operand A; sampled when start is accepted.
- op_b  in  32  operand B; sampled when start is accepted.
- pc_in  in  32  current Datapath PC.
- res_in  in  32  Datapath register 30 (result register).
- cpu_rst  out  1  active-high reset to the Datapath.
- dm_we  out  1  data-memory write strobe.
- dm_addr  out  ADDR_W  data-memory write address.
- dm_wdata  out  32  data-memory write data.
- busy  out  1  a run is in progress.
- done  out  1  the run has finished; stays high until the next accepted start.
- timeout  out  1  the run ended by budget exhaustion.
- result  out  32  latched res_in.
- cycles  out  CYC_W  RUN cycles consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cpu_rst=1.
  - dm_we=0, dm_addr=0, dm_wdata=0.
  - busy=0, done=0, timeout=0, result=0, cycles=0.
  - Internal pc_prev=0 and stable count=0.
  - A reset mid-run aborts immediately; no partial outputs are kept.
- All outputs are registered. States are IDLE, LOAD_A, LOAD_B, RELEASE, RUN, DONE.
- IDLE / DONE:
  - cpu_rst=1, dm_we=0.
  - start=1 latches op_a and op_b, clears done, timeout and cycles, sets busy=1, and moves to LOAD_A.
  - Last result is held until the next start.
- LOAD_A: dm_we=1, dm_addr=OPA_ADDR, dm_wdata=op_a (latched). Next state LOAD_B.
- LOAD_B: dm_we=1, dm_addr=OPB_ADDR, dm_wdata=op_b (latched). Next state RELEASE.
- RELEASE:
  - dm_we=0, cpu_rst held at 1 for this cycle so the PC restarts at 0.
  - cycles=0, stable count=0. Next state RUN.
- RUN:
  - cpu_rst=0; cycles increments every cycle.
  - Each cycle: pc_prev<=pc_in. If pc_in==pc_prev, stable count increments (saturating); otherwise it clears.
  - Halt: stable count reaches HALT_STABLE-1 while pc_in==pc_prev. Then result<=res_in, done=1, busy=0, timeout=0, next state DONE.
  - Timeout: cycles reaches MAX_CYCLES with no halt. Then result<=res_in, done=1, timeout=1, busy=0, next state DONE.
  - If halt and timeout occur in the same cycle, halt wins and timeout=0.
  - cycles never wraps, because it freezes on entry to DONE.
- start is ignored in LOAD_A, LOAD_B, RELEASE and RUN, with no queuing.
- On start in DONE, done drops in the same edge that busy rises.
- Latency, start to first dm_we: 1 cycle. Start to Datapath release: 4 cycles.

Optional Feature:
- Macro: RUN_CTRL_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in any busy state moves to DONE next edge with done=1, aborted=1, timeout=0, cpu_rst=1.
  - result keeps its previous value.
  - A halt or timeout in the same RUN cycle loses to abort.
  - aborted clears on the next accepted start.
- When undefined: both ports are absent and the behaviour is exactly as above.

Test Plan:
- Reset then GCD run: rst low 2 cycles, start with op_a=48, op_b=18 and the GCD program loaded. Required: dm writes (0,48) then (1,18) on consecutive cycles; done=1, timeout=0, result=6, cycles < 1000.
- Timeout: program whose PC never repeats, MAX_CYCLES=1000. Required: done=1 and timeout=1 exactly 1000 RUN cycles after release; cycles=1000.
- Halt/timeout coincidence: PC stalls so the halt condition lands on the cycle where cycles=MAX_CYCLES. Required: done=1, timeout=0.
- start while busy: pulse start during RUN with op_a=99. Required: no dm write, run unaffected, result still from the original operands. Then start in DONE with 35, 21: done drops, busy rises, result becomes 7.
- Mid-run reset: assert rst while in RUN. Required: cpu_rst=1, busy=0, done=0 and all outputs at reset values in the same cycle, without waiting for a clock edge.
- RUN_CTRL_ABORT_EN defined: abort at RUN cycle 10. Required: next edge gives done=1, aborted=1, timeout=0, cpu_rst=1; result unchanged from the prior run.
